// File: rtl/stock_keeper.sv
// stock_keeper: stock counts, per-item sales audit and a 4-phase refill
// handshake with an external supplier on the supply side of vending_machine.
//
// Handshake (refill_req / refill_ack, 4-phase): refill_req rises in REQ with
// refill_item stable; the supplier raises refill_ack and the quantity on
// refill_qty is added on the first edge that samples ack high in REQ. The
// request then drops (REL), and the FSM waits for ack to fall before it may
// issue the next request. An ack seen outside REQ has no effect.
module stock_keeper #(
  parameter int CNT_W      = 2,
  parameter int INIT_STOCK = 3,
  parameter int LOW_MARK   = 1,
  parameter int SALES_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               deliver_tea,
  input  logic               deliver_coffee,
  input  logic               change,
  input  logic               refill_ack,
  input  logic [CNT_W-1:0]   refill_qty,
  output logic [CNT_W-1:0]   tea_loaded,
  output logic [CNT_W-1:0]   coffee_loaded,
  output logic               tea_empty,
  output logic               coffee_empty,
  output logic               refill_req,
  output logic               refill_item,
  output logic [SALES_W-1:0] tea_sold,
  output logic [SALES_W-1:0] coffee_sold,
  output logic [SALES_W-1:0] change_count,
  output logic               underflow_err,
  output logic [1:0]         fsm_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  localparam logic [CNT_W-1:0] INIT_C = INIT_STOCK[CNT_W-1:0];
  localparam logic [CNT_W-1:0] LOW_C  = LOW_MARK[CNT_W-1:0];
  // MAX_STOCK widened by one bit so the refill sum can be clamped.
  localparam logic [CNT_W:0]   MAX_C  = {1'b0, {CNT_W{1'b1}}};

  logic [1:0] state;
  logic       tea_prev;
  logic       coffee_prev;
  logic       change_prev;

  logic       tea_ev;
  logic       coffee_ev;
  logic       change_ev;
  logic       ack_take;
  logic       tea_dec;
  logic       coffee_dec;
  logic [CNT_W-1:0] tea_next;
  logic [CNT_W-1:0] coffee_next;

  // Stock after an optional delivery and optional refill, computed one bit
  // wider than the count and clamped to MAX_STOCK. A delivery never drives
  // the sum negative because it only decrements a non-zero stock.
  function automatic logic [CNT_W-1:0] next_stock(
    input logic [CNT_W-1:0] cur,
    input logic             ev,
    input logic             add_en,
    input logic [CNT_W-1:0] qty
  );
    logic [CNT_W:0] sum;
    sum = {1'b0, cur};
    if (ev && (cur != '0)) sum = sum - {{CNT_W{1'b0}}, 1'b1};
    if (add_en) sum = sum + {1'b0, qty};
    if (sum > MAX_C) sum = MAX_C;
    return sum[CNT_W-1:0];
  endfunction

  // Rising-edge events and per-item stock updates for this cycle.
  always_comb begin
    tea_ev      = deliver_tea && !tea_prev;
    coffee_ev   = deliver_coffee && !coffee_prev;
    change_ev   = change && !change_prev;
    ack_take    = (state == ST_REQ) && refill_ack;
    tea_dec     = tea_ev && (tea_loaded != '0);
    coffee_dec  = coffee_ev && (coffee_loaded != '0);
    tea_next    = next_stock(tea_loaded, tea_ev, ack_take && refill_item, refill_qty);
    coffee_next = next_stock(coffee_loaded, coffee_ev, ack_take && !refill_item, refill_qty);
  end

  // Stock, audit counters, error flag and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      tea_prev      <= 1'b0;
      coffee_prev   <= 1'b0;
      change_prev   <= 1'b0;
      tea_loaded    <= INIT_C;
      coffee_loaded <= INIT_C;
      tea_sold      <= '0;
      coffee_sold   <= '0;
      change_count  <= '0;
      underflow_err <= 1'b0;
    end else begin
      tea_prev      <= deliver_tea;
      coffee_prev   <= deliver_coffee;
      change_prev   <= change;
      tea_loaded    <= tea_next;
      coffee_loaded <= coffee_next;
      if (tea_dec && (tea_sold != '1)) tea_sold <= tea_sold + SALES_W'(1);
      if (coffee_dec && (coffee_sold != '1)) coffee_sold <= coffee_sold + SALES_W'(1);
      if (change_ev && (change_count != '1)) change_count <= change_count + SALES_W'(1);
      if ((tea_ev && (tea_loaded == '0)) || (coffee_ev && (coffee_loaded == '0)))
        underflow_err <= 1'b1;
    end
  end

  // Refill handshake FSM; the low-water check uses the registered stock, so
  // a request appears one edge after the stock reaches the mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      refill_item <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tea_loaded <= LOW_C) begin
            refill_item <= 1'b1;
            state       <= ST_REQ;
          end else if (coffee_loaded <= LOW_C) begin
            refill_item <= 1'b0;
            state       <= ST_REQ;
          end
        end
        ST_REQ:  if (refill_ack) state <= ST_REL;
        ST_REL:  if (!refill_ack) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign refill_req   = (state == ST_REQ);
  assign tea_empty    = (tea_loaded == '0);
  assign coffee_empty = (coffee_loaded == '0);
  assign fsm_state    = state;

endmodule

// File: tb/tb_stock_keeper.sv
// Bench for stock_keeper: directed scenarios plus randomized traffic, all
// checked against a behavioural model of stock, audit and handshake rules.
module tb_stock_keeper;

  localparam int MAXS = 3;
  localparam int LOW  = 1;
  localparam int SMAX = 255;

  logic       clk;
  logic       rst;
  logic       deliver_tea, deliver_coffee, change, refill_ack;
  logic [1:0] refill_qty;
  logic [1:0] tea_loaded, coffee_loaded;
  logic       tea_empty, coffee_empty, refill_req, refill_item, underflow_err;
  logic [7:0] tea_sold, coffee_sold, change_count;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  // model state
  int m_tea, m_cof, m_ts, m_cs, m_chg;
  bit m_err, m_req, m_rel, m_item;
  bit p_t, p_c, p_ch;

  logic [1:0] exp_q[$];

  stock_keeper dut (
    .clk(clk), .rst(rst),
    .deliver_tea(deliver_tea), .deliver_coffee(deliver_coffee),
    .change(change), .refill_ack(refill_ack), .refill_qty(refill_qty),
    .tea_loaded(tea_loaded), .coffee_loaded(coffee_loaded),
    .tea_empty(tea_empty), .coffee_empty(coffee_empty),
    .refill_req(refill_req), .refill_item(refill_item),
    .tea_sold(tea_sold), .coffee_sold(coffee_sold),
    .change_count(change_count), .underflow_err(underflow_err),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the specification rules to one clock edge using the inputs seen there.
  task automatic model_update();
    bit et, ec, ech, take, nreq, nrel, nitem;
    int old_t, old_c;
    if (rst) begin
      m_tea = MAXS; m_cof = MAXS; m_ts = 0; m_cs = 0; m_chg = 0;
      m_err = 0; m_req = 0; m_rel = 0; m_item = 1;
      p_t = 0; p_c = 0; p_ch = 0;
    end else begin
      et = deliver_tea && !p_t;
      ec = deliver_coffee && !p_c;
      ech = change && !p_ch;
      take = m_req && refill_ack;
      old_t = m_tea; old_c = m_cof;
      nreq = m_req; nrel = m_rel; nitem = m_item;
      if (m_req) begin
        if (refill_ack) begin nreq = 0; nrel = 1; end
      end else if (m_rel) begin
        if (!refill_ack) nrel = 0;
      end else if (old_t <= LOW) begin
        nreq = 1; nitem = 1;
      end else if (old_c <= LOW) begin
        nreq = 1; nitem = 0;
      end
      if (et) begin
        if (old_t > 0) begin m_tea = m_tea - 1; if (m_ts < SMAX) m_ts++; end
        else m_err = 1;
      end
      if (ec) begin
        if (old_c > 0) begin m_cof = m_cof - 1; if (m_cs < SMAX) m_cs++; end
        else m_err = 1;
      end
      if (take && m_item)  m_tea = (m_tea + int'(refill_qty) > MAXS) ? MAXS : m_tea + int'(refill_qty);
      if (take && !m_item) m_cof = (m_cof + int'(refill_qty) > MAXS) ? MAXS : m_cof + int'(refill_qty);
      if (ech && m_chg < SMAX) m_chg++;
      m_req = nreq; m_rel = nrel; m_item = nitem;
      p_t = deliver_tea; p_c = deliver_coffee; p_ch = change;
    end
  endtask

  // driver: one clock edge, model update, then settle for sampling
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; deliver_tea = 0; deliver_coffee = 0; change = 0;
    refill_ack = 0; refill_qty = 0;
    step(); step();
    rst = 0;
    checks++; if (tea_loaded !== 2'd3) begin errors++; $display("FAIL reset_tea: got %0d exp 3", tea_loaded); end
    checks++; if (coffee_loaded !== 2'd3) begin errors++; $display("FAIL reset_coffee: got %0d exp 3", coffee_loaded); end
    checks++; if (refill_req !== 1'b0 || refill_item !== 1'b1) begin errors++; $display("FAIL reset_fsm: req=%b item=%b exp 0/1", refill_req, refill_item); end
    checks++; if (tea_sold !== 8'd0 || coffee_sold !== 8'd0 || change_count !== 8'd0 || underflow_err !== 1'b0)
      begin errors++; $display("FAIL reset_counters: ts=%0d cs=%0d ch=%0d err=%b exp 0", tea_sold, coffee_sold, change_count, underflow_err); end
    checks++; if (tea_empty !== 1'b0 || coffee_empty !== 1'b0) begin errors++; $display("FAIL reset_empty: %b %b exp 0 0", tea_empty, coffee_empty); end
  endtask

  task automatic test_deliveries();
    deliver_tea = 1;
    step();
    checks++; if (tea_loaded !== 2'd2) begin errors++; $display("FAIL deliv_first: got %0d exp 2", tea_loaded); end
    step(); step();
    checks++; if (tea_loaded !== 2'd2 || tea_sold !== 8'd1) begin errors++; $display("FAIL deliv_level: tea=%0d sold=%0d exp 2/1", tea_loaded, tea_sold); end
    deliver_tea = 0; step();
    deliver_tea = 1; step();
    checks++; if (tea_loaded !== 2'd1 || tea_sold !== 8'd2 || refill_req !== 1'b0)
      begin errors++; $display("FAIL deliv_second: tea=%0d sold=%0d req=%b exp 1/2/0", tea_loaded, tea_sold, refill_req); end
    deliver_tea = 0; step();
    checks++; if (refill_req !== 1'b1 || refill_item !== 1'b1) begin errors++; $display("FAIL deliv_req: req=%b item=%b exp 1/1", refill_req, refill_item); end
  endtask

  task automatic test_handshake();
    refill_ack = 1; refill_qty = 2'd3; step();
    checks++; if (tea_loaded !== 2'd3 || refill_req !== 1'b0) begin errors++; $display("FAIL hs_ack: tea=%0d req=%b exp 3/0", tea_loaded, refill_req); end
    step(); step();
    checks++; if (refill_req !== 1'b0 || tea_loaded !== 2'd3) begin errors++; $display("FAIL hs_hold: req=%b tea=%0d exp 0/3", refill_req, tea_loaded); end
    refill_ack = 0; refill_qty = 0; step(); step(); step();
    checks++; if (refill_req !== 1'b0 || coffee_loaded !== 2'd3) begin errors++; $display("FAIL hs_idle: req=%b coffee=%0d exp 0/3", refill_req, coffee_loaded); end
  endtask

  task automatic test_priority();
    deliver_tea = 1; deliver_coffee = 1; step();
    deliver_tea = 0; deliver_coffee = 0; step();
    deliver_tea = 1; deliver_coffee = 1; step();
    checks++; if (tea_loaded !== 2'd1 || coffee_loaded !== 2'd1 || refill_req !== 1'b0)
      begin errors++; $display("FAIL prio_stock: tea=%0d coffee=%0d req=%b exp 1/1/0", tea_loaded, coffee_loaded, refill_req); end
    deliver_tea = 0; deliver_coffee = 0; step();
    checks++; if (refill_req !== 1'b1 || refill_item !== 1'b1) begin errors++; $display("FAIL prio_tea_first: req=%b item=%b exp 1/1", refill_req, refill_item); end
    refill_ack = 1; refill_qty = 2'd2; step();
    checks++; if (tea_loaded !== 2'd3 || coffee_loaded !== 2'd1) begin errors++; $display("FAIL prio_tea_fill: tea=%0d coffee=%0d exp 3/1", tea_loaded, coffee_loaded); end
    refill_ack = 0; step(); step();
    checks++; if (refill_req !== 1'b1 || refill_item !== 1'b0) begin errors++; $display("FAIL prio_coffee_next: req=%b item=%b exp 1/0", refill_req, refill_item); end
    refill_ack = 1; step();
    checks++; if (coffee_loaded !== 2'd3 || refill_req !== 1'b0) begin errors++; $display("FAIL prio_coffee_fill: coffee=%0d req=%b exp 3/0", coffee_loaded, refill_req); end
    refill_ack = 0; refill_qty = 0; step(); step();
  endtask

  task automatic test_underflow();
    logic [7:0] sold_before;
    for (int i = 0; i < 3; i++) begin
      deliver_coffee = 1; step();
      deliver_coffee = 0; step();
    end
    checks++; if (coffee_loaded !== 2'd0 || coffee_empty !== 1'b1 || underflow_err !== 1'b0)
      begin errors++; $display("FAIL uf_drain: coffee=%0d empty=%b err=%b exp 0/1/0", coffee_loaded, coffee_empty, underflow_err); end
    sold_before = coffee_sold;
    deliver_coffee = 1; step();
    checks++; if (coffee_loaded !== 2'd0 || coffee_sold !== sold_before || underflow_err !== 1'b1)
      begin errors++; $display("FAIL uf_event: coffee=%0d sold=%0d err=%b exp 0/%0d/1", coffee_loaded, coffee_sold, underflow_err, sold_before); end
    deliver_coffee = 0;
    for (int i = 0; i < 5; i++) step();
    checks++; if (underflow_err !== 1'b1 || refill_req !== 1'b1 || refill_item !== 1'b0)
      begin errors++; $display("FAIL uf_sticky: err=%b req=%b item=%b exp 1/1/0", underflow_err, refill_req, refill_item); end
  endtask

  task automatic test_mid_reset();
    refill_ack = 1; refill_qty = 2'd1; rst = 1; step();
    checks++; if (refill_req !== 1'b0 || tea_loaded !== 2'd3 || coffee_loaded !== 2'd3)
      begin errors++; $display("FAIL mrst_stock: req=%b tea=%0d coffee=%0d exp 0/3/3", refill_req, tea_loaded, coffee_loaded); end
    checks++; if (tea_sold !== 8'd0 || coffee_sold !== 8'd0 || change_count !== 8'd0 || underflow_err !== 1'b0 || refill_item !== 1'b1)
      begin errors++; $display("FAIL mrst_counters: ts=%0d cs=%0d ch=%0d err=%b item=%b", tea_sold, coffee_sold, change_count, underflow_err, refill_item); end
    rst = 0; step();
    checks++; if (refill_req !== 1'b0 || coffee_loaded !== 2'd3) begin errors++; $display("FAIL mrst_ack_ignored: req=%b coffee=%0d exp 0/3", refill_req, coffee_loaded); end
    refill_ack = 0; refill_qty = 0; step();
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 2; i++) begin
      deliver_tea = 1; step();
      deliver_tea = 0; step();
    end
    checks++; if (tea_loaded !== 2'd1 || refill_req !== 1'b1) begin errors++; $display("FAIL sim_setup: tea=%0d req=%b exp 1/1", tea_loaded, refill_req); end
    deliver_tea = 1; refill_ack = 1; refill_qty = 2'd2; step();
    checks++; if (tea_loaded !== 2'd2 || tea_sold !== 8'd3 || refill_req !== 1'b0)
      begin errors++; $display("FAIL sim_both: tea=%0d sold=%0d req=%b exp 2/3/0", tea_loaded, tea_sold, refill_req); end
    deliver_tea = 0; refill_ack = 0; refill_qty = 0; step(); step();
    refill_ack = 1; refill_qty = 2'd3; step();
    checks++; if (tea_loaded !== 2'd2 || refill_req !== 1'b0) begin errors++; $display("FAIL ack_outside_req: tea=%0d req=%b exp 2/0", tea_loaded, refill_req); end
    refill_ack = 0; refill_qty = 0; step();
  endtask

  task automatic test_change_saturation();
    for (int i = 0; i < 300; i++) begin
      change = 1; step();
      change = 0; step();
      if (i == 9) begin
        checks++; if (change_count !== 8'd10) begin errors++; $display("FAIL change_count10: got %0d exp 10", change_count); end
      end
    end
    checks++; if (change_count !== 8'd255) begin errors++; $display("FAIL change_sat: got %0d exp 255", change_count); end
  endtask

  task automatic test_random();
    logic [1:0] exp_tea;
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 199) == 0);
      deliver_tea    = ($urandom_range(0, 2) == 0);
      deliver_coffee = ($urandom_range(0, 2) == 0);
      change         = $urandom_range(0, 1);
      refill_qty     = 2'($urandom_range(0, 3));
      if (refill_req && $urandom_range(0, 2) == 0) refill_ack = 1;
      else if (!refill_req && $urandom_range(0, 2) == 0) refill_ack = 0;
      else if ($urandom_range(0, 30) == 0) refill_ack = ~refill_ack;
      step();
      exp_q.push_back(2'(m_tea));
      exp_tea = exp_q.pop_front();
      checks++; if (tea_loaded !== exp_tea) begin errors++; $display("FAIL rnd_tea @%0d: got %0d exp %0d", n, tea_loaded, exp_tea); end
      checks++; if (coffee_loaded !== 2'(m_cof) || coffee_empty !== (m_cof == 0) || tea_empty !== (m_tea == 0))
        begin errors++; $display("FAIL rnd_coffee @%0d: got %0d/%b/%b exp %0d", n, coffee_loaded, coffee_empty, tea_empty, m_cof); end
      checks++; if (refill_req !== m_req || (m_req && refill_item !== m_item))
        begin errors++; $display("FAIL rnd_req @%0d: req=%b item=%b exp %b/%b", n, refill_req, refill_item, m_req, m_item); end
      checks++; if (tea_sold !== 8'(m_ts) || coffee_sold !== 8'(m_cs) || change_count !== 8'(m_chg) || underflow_err !== m_err)
        begin errors++; $display("FAIL rnd_audit @%0d: ts=%0d cs=%0d ch=%0d err=%b exp %0d/%0d/%0d/%b", n, tea_sold, coffee_sold, change_count, underflow_err, m_ts, m_cs, m_chg, m_err); end
    end
    rst = 0; refill_ack = 0; deliver_tea = 0; deliver_coffee = 0; change = 0;
  endtask

  initial begin
    test_reset();
    test_deliveries();
    test_handshake();
    test_priority();
    test_underflow();
    test_mid_reset();
    test_simultaneous();
    test_change_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
